// File: rtl/wall_pkg.sv
// wall_pkg: shared types and defaults for the wall collision block
package wall_pkg;
    localparam int NUM_WALLS_DEF = 25;
    localparam int POS_W_DEF = 8;
    typedef logic [POS_W_DEF-1:0] pos_t;
    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} wall_state_t;
    typedef enum logic {GNT_HEAD, GNT_APPLE} grant_t;
endpackage

// File: rtl/wall_match_cmp.sv
// wall_match_cmp: one position against every stored wall slot, masked by slot valid
//   pos      - cell under test
//   slot_pos - stored wall cells
//   slot_vld - per-slot valid; empty slots never match
//   hit      - any valid slot equals pos
module wall_match_cmp #(
    parameter int NUM_WALLS = 25,
    parameter int POS_W = 8
) (
    input  logic [POS_W-1:0]     pos,
    input  logic [POS_W-1:0]     slot_pos [NUM_WALLS],
    input  logic [NUM_WALLS-1:0] slot_vld,
    output logic                 hit
);
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_WALLS; i++) hit = hit | (slot_vld[i] && slot_pos[i] == pos);
    end
endmodule

// File: rtl/wall_collision_ctrl.sv
// wall_collision_ctrl: wall set loader plus round-robin shared collision query port
//   game_start              - clears walls, enters LOAD
//   wall_valid/pos/ready    - wall load stream, duplicates dropped
//   load_done, wall_count   - wall set complete / walls stored
//   req/pos/resp/hit _head  - head-mover query, resp one cycle after grant
//   req/pos/resp/hit _apple - apple-spawner query, resp one cycle after grant
module wall_collision_ctrl
    import wall_pkg::*;
#(
    parameter int NUM_WALLS = NUM_WALLS_DEF,
    parameter int POS_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           game_start,
    input  logic                           wall_valid,
    input  logic [POS_W-1:0]               wall_pos,
    output logic                           wall_ready,
    output logic                           load_done,
    output logic [$clog2(NUM_WALLS+1)-1:0] wall_count,
    input  logic                           req_head,
    input  logic [POS_W-1:0]               head_pos,
    output logic                           resp_head,
    output logic                           hit_head,
    input  logic                           req_apple,
    input  logic [POS_W-1:0]               apple_pos,
    output logic                           resp_apple,
    output logic                           hit_apple
);
    localparam int CW = $clog2(NUM_WALLS + 1);
    wall_state_t state_q, state_d;
    logic [POS_W-1:0] slot_pos_q [NUM_WALLS];
    logic [POS_W-1:0] slot_pos_d [NUM_WALLS];
    logic [NUM_WALLS-1:0] slot_vld_q, slot_vld_d;
    logic [CW-1:0] count_q, count_d;
    grant_t last_q, last_d;
    logic resp_head_q, resp_head_d, resp_apple_q, resp_apple_d;
    logic hit_head_q, hit_head_d, hit_apple_q, hit_apple_d;
    logic elig_head, elig_apple, gnt_head, gnt_apple, accept, match;
    logic [POS_W-1:0] cmp_pos;

    // loading and querying never overlap, so one comparator serves both
    wall_match_cmp #(.NUM_WALLS(NUM_WALLS), .POS_W(POS_W)) u_cmp (
        .pos(cmp_pos),
        .slot_pos(slot_pos_q),
        .slot_vld(slot_vld_q),
        .hit(match)
    );

    always_comb begin
        // a requester in its resp cycle is not eligible, so a held req is not re-granted
        elig_head = req_head && !resp_head_q;
        elig_apple = req_apple && !resp_apple_q;
        gnt_head = state_q == ACTIVE && !game_start && elig_head && (!elig_apple || last_q == GNT_APPLE);
        gnt_apple = state_q == ACTIVE && !game_start && elig_apple && !gnt_head;
        accept = state_q == LOAD && wall_valid && !game_start;
        cmp_pos = state_q == LOAD ? wall_pos : gnt_head ? head_pos : apple_pos;
        state_d = state_q;
        slot_pos_d = slot_pos_q;
        slot_vld_d = slot_vld_q;
        count_d = count_q;
        last_d = last_q;
        resp_head_d = gnt_head;
        resp_apple_d = gnt_apple;
        hit_head_d = gnt_head ? match : hit_head_q;
        hit_apple_d = gnt_apple ? match : hit_apple_q;
        if (gnt_head) last_d = GNT_HEAD;
        if (gnt_apple) last_d = GNT_APPLE;
        if (game_start) begin
            state_d = LOAD;
            slot_vld_d = '0;
            count_d = '0;
        end else if (accept && !match) begin
            for (int i = 0; i < NUM_WALLS; i++) begin
                if (count_q == CW'(i)) begin
                    slot_pos_d[i] = wall_pos;
                    slot_vld_d[i] = 1'b1;
                end
            end
            count_d = count_q + 1'b1;
            if (count_q == CW'(NUM_WALLS - 1)) state_d = ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        slot_pos_q <= slot_pos_d;
        if (rst) begin
            state_q <= IDLE;
            slot_vld_q <= '0;
            count_q <= '0;
            last_q <= GNT_APPLE;
            resp_head_q <= 1'b0;
            resp_apple_q <= 1'b0;
            hit_head_q <= 1'b0;
            hit_apple_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_vld_q <= slot_vld_d;
            count_q <= count_d;
            last_q <= last_d;
            resp_head_q <= resp_head_d;
            resp_apple_q <= resp_apple_d;
            hit_head_q <= hit_head_d;
            hit_apple_q <= hit_apple_d;
        end
    end

    assign wall_ready = state_q == LOAD;
    assign load_done = state_q == ACTIVE;
    assign wall_count = count_q;
    assign resp_head = resp_head_q;
    assign resp_apple = resp_apple_q;
    assign hit_head = hit_head_q;
    assign hit_apple = hit_apple_q;
endmodule

// File: tb/tb_wall_collision_ctrl.sv
// tb_wall_collision_ctrl: table vectors, directed sequences and random traffic against a set-based model
module tb_wall_collision_ctrl;
    localparam int NW = 25;
    logic clk = 1'b0;
    logic rst, game_start, wall_valid, req_head, req_apple;
    logic [7:0] wall_pos, head_pos, apple_pos;
    logic wall_ready, load_done, resp_head, hit_head, resp_apple, hit_apple;
    logic [4:0] wall_count;
    int checks = 0;
    int errors = 0;
    bit m_started, m_resp_h, m_resp_a, m_hit_h, m_hit_a, m_last_apple;
    logic [7:0] m_walls [$];
    bit keep_h, keep_a;

    typedef struct {
        bit gs; bit wv; logic [7:0] wp; bit rh; logic [7:0] hp; bit ra; logic [7:0] ap;
        bit e_ready; bit e_done; int e_count; bit e_rh; bit e_ra;
    } vec_t;
    vec_t tbl [9];

    wall_collision_ctrl dut (
        .clk(clk), .rst(rst), .game_start(game_start),
        .wall_valid(wall_valid), .wall_pos(wall_pos), .wall_ready(wall_ready),
        .load_done(load_done), .wall_count(wall_count),
        .req_head(req_head), .head_pos(head_pos), .resp_head(resp_head), .hit_head(hit_head),
        .req_apple(req_apple), .apple_pos(apple_pos), .resp_apple(resp_apple), .hit_apple(hit_apple)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has(logic [7:0] p);
        foreach (m_walls[i]) if (m_walls[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // the wall set is a queue; ready/done/count all follow from its size
    task automatic model_eval();
        bit done, ready, eh, ea, gh, ga;
        if (rst) begin
            m_started = 0; m_walls.delete();
            m_resp_h = 0; m_resp_a = 0; m_hit_h = 0; m_hit_a = 0; m_last_apple = 1;
            return;
        end
        done = m_started && m_walls.size() == NW;
        ready = m_started && m_walls.size() < NW;
        eh = req_head && !m_resp_h;
        ea = req_apple && !m_resp_a;
        gh = 0; ga = 0;
        if (done && !game_start) begin
            if (eh && ea) begin gh = m_last_apple; ga = !m_last_apple; end
            else begin gh = eh; ga = ea; end
        end
        m_resp_h = gh; m_resp_a = ga;
        if (gh) begin m_hit_h = has(head_pos); m_last_apple = 0; end
        if (ga) begin m_hit_a = has(apple_pos); m_last_apple = 1; end
        if (game_start) begin m_started = 1; m_walls.delete(); end
        else if (ready && wall_valid && !has(wall_pos)) m_walls.push_back(wall_pos);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        check("wall_ready", wall_ready, m_started && m_walls.size() < NW);
        check("load_done", load_done, m_started && m_walls.size() == NW);
        check("wall_count", wall_count, m_walls.size());
        check("resp_head", resp_head, m_resp_h);
        check("hit_head", hit_head, m_hit_h);
        check("resp_apple", resp_apple, m_resp_a);
        check("hit_apple", hit_apple, m_hit_a);
        game_start = 0;
        rst = 0;
        if (resp_head && !keep_h) req_head = 0;
        if (resp_apple && !keep_a) req_apple = 0;
    endtask

    task automatic load_cell(logic [7:0] p);
        wall_valid = 1; wall_pos = p;
        step();
        wall_valid = 0;
    endtask

    initial begin
        int n;
        bit got;
        bit seen_hit;
        rst = 1; game_start = 0; wall_valid = 0; wall_pos = 0;
        req_head = 0; head_pos = 0; req_apple = 0; apple_pos = 0;
        keep_h = 0; keep_a = 0;
        step();
        rst = 1;
        step();
        check("reset wall_ready", wall_ready, 0);
        check("reset load_done", load_done, 0);
        check("reset wall_count", wall_count, 0);
        check("reset resp", {resp_head, resp_apple, hit_head, hit_apple}, 0);

        tbl[0] = '{0, 0, 8'h00, 1, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 8'h00, 1, 8'h00, 1, 8'h00, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 8'h33, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0};
        tbl[3] = '{0, 1, 8'h33, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0};
        tbl[4] = '{0, 1, 8'h00, 1, 8'h00, 0, 8'h00, 1, 0, 2, 0, 0};
        tbl[5] = '{0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 1, 0, 2, 0, 0};
        tbl[6] = '{1, 1, 8'h55, 1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 8'h00, 1, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0};
        tbl[8] = '{0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            game_start = tbl[i].gs; wall_valid = tbl[i].wv; wall_pos = tbl[i].wp;
            req_head = tbl[i].rh; head_pos = tbl[i].hp; req_apple = tbl[i].ra; apple_pos = tbl[i].ap;
            step();
            check($sformatf("tbl%0d ready", i), wall_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d done", i), load_done, tbl[i].e_done);
            check($sformatf("tbl%0d count", i), wall_count, tbl[i].e_count);
            check($sformatf("tbl%0d resp_head", i), resp_head, tbl[i].e_rh);
            check($sformatf("tbl%0d resp_apple", i), resp_apple, tbl[i].e_ra);
        end
        wall_valid = 0; req_head = 0; req_apple = 0;

        game_start = 1;
        step();
        check("A ready after start", wall_ready, 1);
        for (int i = 0; i < NW; i++) load_cell(8'(i));
        check("A count", wall_count, 25);
        check("A done", load_done, 1);
        check("A ready low", wall_ready, 0);
        req_head = 1; head_pos = 8'h05;
        step();
        check("A head resp", resp_head, 1);
        check("A head hit", hit_head, 1);
        req_apple = 1; apple_pos = 8'hEE;
        step();
        check("A apple resp", resp_apple, 1);
        check("A apple hit", hit_apple, 0);

        keep_h = 1; keep_a = 1;
        req_head = 1; head_pos = 8'h07; req_apple = 1; apple_pos = 8'h99;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("alt%0d resp_head", k), resp_head, k % 2 == 0);
            check($sformatf("alt%0d resp_apple", k), resp_apple, k % 2 == 1);
        end
        keep_h = 0; keep_a = 0; req_head = 0; req_apple = 0;
        step();
        step();

        game_start = 1;
        step();
        load_cell(8'h33);
        load_cell(8'h33);
        check("B dup dropped", wall_count, 1);
        for (int i = 0; i < 23; i++) load_cell(8'h40 + 8'(i));
        check("B count 24", wall_count, 24);
        check("B not done", load_done, 0);
        load_cell(8'h57);
        check("B count 25", wall_count, 25);
        check("B done", load_done, 1);

        game_start = 1;
        step();
        req_head = 1; head_pos = 8'h00;
        n = 0;
        load_cell(8'h11); n += int'(resp_head);
        load_cell(8'h22); n += int'(resp_head);
        load_cell(8'h44); n += int'(resp_head);
        check("C count 3", wall_count, 3);
        for (int i = 0; i < 22; i++) begin
            load_cell(8'h60 + 8'(i));
            n += int'(resp_head);
        end
        check("C no resp in load", n, 0);
        got = 0; seen_hit = 1;
        for (int k = 0; k < 5 && !got; k++) begin
            step();
            if (resp_head) begin got = 1; seen_hit = hit_head; end
        end
        check("C resp seen", got, 1);
        check("C hit 0x00", seen_hit, 0);

        req_apple = 1; apple_pos = 8'h60; game_start = 1;
        step();
        check("D done low", load_done, 0);
        check("D count 0", wall_count, 0);
        check("D no resp", resp_apple, 0);
        n = 0;
        for (int i = 0; i < NW; i++) begin
            load_cell(8'h60 + 8'(i));
            n += int'(resp_apple);
        end
        check("D no resp in reload", n, 0);
        got = 0; seen_hit = 0;
        for (int k = 0; k < 5 && !got; k++) begin
            step();
            if (resp_apple) begin got = 1; seen_hit = hit_apple; end
        end
        check("D resp seen", got, 1);
        check("D hit 0x60", seen_hit, 1);

        req_head = 1; head_pos = 8'h61; rst = 1;
        step();
        check("R resp killed", resp_head, 0);
        check("R done low", load_done, 0);
        check("R count 0", wall_count, 0);
        req_head = 0;
        step();

        for (int c = 0; c < 2000; c++) begin
            game_start = ($urandom % 150) == 0;
            rst = ($urandom % 400) == 0;
            wall_valid = ($urandom % 4) != 0;
            wall_pos = 8'($urandom % 64);
            if (!req_head && ($urandom % 3) == 0) begin req_head = 1; head_pos = 8'($urandom % 64); end
            if (!req_apple && ($urandom % 3) == 0) begin req_apple = 1; apple_pos = 8'($urandom % 64); end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
